// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
//
// Shares the byte-wide data memory between the CPU load/store path and the
// debug/loader port. One 32-bit word access at a time, sequenced as four
// single-byte memory beats, most significant byte first (big-endian words).
//
// Ports
//   clk, reset                       clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata            CPU request (level), write flag, byte addr, word
//   cpu_rdata, cpu_ack               CPU read word (held), one-cycle completion
//   dbg_req/we/addr/wdata            debug request, same meaning as cpu_*
//   dbg_rdata, dbg_ack               debug read word (held), one-cycle completion
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata             byte memory port, read data one cycle late
//   busy                             transaction in progress (state != IDLE)
//   grant_id                         0 = CPU, 1 = debug owns the transaction
//   err                              pulses with ack on a rejected access
// -----------------------------------------------------------------------------
module dm_port_arbiter #(
    parameter int Mbit    = 32,
    parameter int AW      = 10,
    parameter int MAXWAIT = 4
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [Mbit-1:0] cpu_addr,
    input  logic [Mbit-1:0] cpu_wdata,
    output logic [Mbit-1:0] cpu_rdata,
    output logic            cpu_ack,

    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [Mbit-1:0] dbg_addr,
    input  logic [Mbit-1:0] dbg_wdata,
    output logic [Mbit-1:0] dbg_rdata,
    output logic            dbg_ack,

    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [7:0]      mem_wdata,
    input  logic [7:0]      mem_rdata,

    output logic            busy,
    output logic            grant_id,
    output logic            err
);

    localparam int WCW = $clog2(MAXWAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        LAST = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t            state_q;
    logic              owner_q;       // 0 = CPU, 1 = debug
    logic              we_q;
    logic [Mbit-1:0]   addr_q;
    logic [Mbit-1:0]   wdata_q;
    logic [1:0]        beat_q;
    logic              rej_q;
    logic [23:0]       asm_q;         // bytes 0..2 of a read, MSB first
    logic [WCW-1:0]    wait_cnt_q;

    logic [Mbit-1:0]   cpu_rdata_q, dbg_rdata_q;
    logic              cpu_ack_q, dbg_ack_q, err_q, busy_q, grant_id_q;
    logic              mem_en_q, mem_we_q;
    logic [AW-1:0]     mem_addr_q;
    logic [7:0]        mem_wdata_q;

    // Arbitration and access check on the live request inputs (used in IDLE only)
    logic              gnt_any_d;
    logic              gnt_dbg_d;
    logic              req_we_d;
    logic [Mbit-1:0]   req_addr_d;
    logic [Mbit-1:0]   req_wdata_d;
    logic              rej_d;
    logic [1:0]        beat_d;

    // Byte lane of a word for a given beat; beat 0 is the most significant byte.
    function automatic logic [7:0] byte_sel(input logic [Mbit-1:0] w, input logic [1:0] b);
        logic [7:0] r;
        case (b)
            2'd0:    r = w[Mbit-1  -: 8];
            2'd1:    r = w[Mbit-9  -: 8];
            2'd2:    r = w[Mbit-17 -: 8];
            default: r = w[Mbit-25 -: 8];
        endcase
        return r;
    endfunction

    // NOTE: every signal gets a value on every path through always_comb, otherwise
    // synthesis infers a latch to hold the old value.
    always_comb begin
        gnt_any_d   = cpu_req | dbg_req;
        // Debug wins when alone, or when the CPU has starved it MAXWAIT times.
        gnt_dbg_d   = dbg_req & (~cpu_req | (wait_cnt_q == WCW'(MAXWAIT)));
        req_we_d    = gnt_dbg_d ? dbg_we    : cpu_we;
        req_addr_d  = gnt_dbg_d ? dbg_addr  : cpu_addr;
        req_wdata_d = gnt_dbg_d ? dbg_wdata : cpu_wdata;
        rej_d       = (req_addr_d[1:0] != 2'b00) || (req_addr_d[Mbit-1:AW] != '0);
        beat_d      = beat_q + 2'd1;
    end

    // NOTE: state registers use non-blocking assignments so every register in this
    // block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            beat_q      <= 2'd0;
            rej_q       <= 1'b0;
            asm_q       <= '0;
            wait_cnt_q  <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            grant_id_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // Pulses and the memory strobe are one cycle wide unless re-armed below.
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;

            case (state_q)
                IDLE: begin
                    if (gnt_any_d) begin
                        state_q    <= XFER;
                        busy_q     <= 1'b1;
                        owner_q    <= gnt_dbg_d;
                        grant_id_q <= gnt_dbg_d;
                        we_q       <= req_we_d;
                        addr_q     <= req_addr_d;
                        wdata_q    <= req_wdata_d;
                        beat_q     <= 2'd0;
                        rej_q      <= rej_d;

                        if (gnt_dbg_d)
                            wait_cnt_q <= '0;
                        else if (dbg_req && (wait_cnt_q != WCW'(MAXWAIT)))
                            wait_cnt_q <= wait_cnt_q + WCW'(1);

                        if (rej_d) begin
                            // Rejected read returns zero; rejected write touches nothing.
                            if (!req_we_d) begin
                                if (gnt_dbg_d) dbg_rdata_q <= '0;
                                else           cpu_rdata_q <= '0;
                            end
                        end else begin
                            // Launch beat 0 so the strobe lines up with the first XFER cycle.
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= req_we_d;
                            mem_addr_q  <= {req_addr_d[AW-1:2], 2'b00};
                            mem_wdata_q <= byte_sel(req_wdata_d, 2'd0);
                        end
                    end
                end

                XFER: begin
                    if (rej_q) begin
                        // Rejected access spends this one cycle with the strobe held off.
                        state_q <= ACK;
                        err_q   <= 1'b1;
                        if (owner_q) dbg_ack_q <= 1'b1;
                        else         cpu_ack_q <= 1'b1;
                    end else begin
                        // Read byte for beat n-1 arrives while beat n is on the bus.
                        if (!we_q && (beat_q != 2'd0))
                            asm_q <= {asm_q[15:0], mem_rdata};
                        beat_q <= beat_d;
                        if (beat_q == 2'd3) begin
                            state_q <= LAST;
                        end else begin
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= we_q;
                            mem_addr_q  <= {addr_q[AW-1:2], beat_d};
                            mem_wdata_q <= byte_sel(wdata_q, beat_d);
                        end
                    end
                end

                LAST: begin
                    state_q <= ACK;
                    if (owner_q) dbg_ack_q <= 1'b1;
                    else         cpu_ack_q <= 1'b1;
                    if (!we_q) begin
                        if (owner_q) dbg_rdata_q <= {asm_q, mem_rdata};
                        else         cpu_rdata_q <= {asm_q, mem_rdata};
                    end
                end

                default: begin // ACK
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ack   = dbg_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;
    assign err       = err_q;

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the byte-wide data memory (8-bit entries, big-endian 32-bit words) between two requesters: the beta CPU load/store path and a debug/loader port used for memory preload and dump.
- Arbitrates between the two requesters and sequences each 32-bit word access as four single-byte memory beats.
- Assembles read data, pulses a per-requester ack, and flags misaligned or out-of-range accesses.
- Sits between the CPU/debug masters and the DM storage array.

Parameters:
- Mbit, 32, requester address/data width.
- AW, 10, byte-address width of the data memory (1024 bytes).
- MAXWAIT, 4, consecutive CPU grants allowed while dbg_req is pending before debug is forced.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, level.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  Mbit  byte address.
- cpu_wdata  in  Mbit  write word.
- cpu_rdata  out  Mbit  read word; updated only by CPU reads.
- cpu_ack  out  1  one-cycle completion pulse.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same as the cpu_* ports, for the debug port.
- mem_en  out  1  memory byte access strobe.
- mem_we  out  1  memory byte write enable.
- mem_addr  out  AW  memory byte address.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  read byte; valid the cycle after mem_en=1 with mem_we=0.
- busy  out  1  transaction in progress (any state other than IDLE).
- grant_id  out  1  0 = CPU, 1 = debug; meaningful while busy.
- err  out  1  one-cycle pulse, coincident with ack, on a rejected access.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0, including cpu_rdata, dbg_rdata, busy, grant_id and err. Starvation counter = 0.
- Reset mid-transaction aborts immediately. Bytes already written stay written; there is no rollback.
- States: IDLE, XFER, LAST, ACK.
- IDLE:
  - Requests are sampled only in IDLE.
  - Winner is the CPU if cpu_req=1, unless dbg_req=1 and wait_cnt==MAXWAIT, in which case debug wins.
  - If only dbg_req=1, debug wins.
  - On a grant, latch owner, we, addr and wdata; set beat=0.
- Access check on grant:
  - Rejected if addr[1:0]!=0 or addr[Mbit-1:AW]!=0.
  - Rejected access: go directly to ACK with err=1. No mem_en is issued. For a read, the owner's rdata is set to 0.
  - Valid access: go to XFER.
- XFER (4 cycles, beat 0..3):
  - mem_en=1, mem_we=we, mem_addr={addr[AW-1:2], beat[1:0]}.
  - mem_wdata = wdata[31-8*beat -: 8] (beat 0 carries bits 31:24).
  - Reads: the byte returned one cycle later is shifted into an assembly register, MSB first.
  - After beat 3, go to LAST.
- LAST (1 cycle): mem_en=0. Reads capture byte 3 and the assembled word is written to the owner's rdata register. Writes do nothing here.
- ACK (1 cycle):
  - The owner's ack=1 (and err if rejected).
  - The owner's rdata is valid here and held until that requester's next read completes.
  - Next state is IDLE.
- Latency: a request sampled in IDLE at cycle t gives ack at t+6 (valid access) or t+2 (rejected). At most one transaction is in flight.
- Requesters must deassert req in the cycle after ack. A req still high in the following IDLE cycle starts a new transaction.
- Starvation counter:
  - Increments (saturating at MAXWAIT) on each CPU grant made while dbg_req=1.
  - Clears on a debug grant.
- cpu_ack and dbg_ack are never high together.
- busy=0 only in IDLE.
- Inputs are ignored outside IDLE. Changes to addr or wdata during a transfer have no effect.

Test Plan:
1. CPU write addr 0x8, data 0x12345678 -> mem bytes 8..11 = 0x12,0x34,0x56,0x78; cpu_ack at t+6; a following CPU read of 0x8 returns cpu_rdata=0x12345678.
2. cpu_req and dbg_req rise in the same cycle -> CPU served first (grant_id=0); debug granted in the IDLE cycle after cpu_ack; dbg_ack 7 cycles after cpu_ack.
3. cpu_req held high continuously, dbg_req held, MAXWAIT=4 -> 4 CPU grants, then the 5th grant goes to debug; counter clears; CPU served next.
4. CPU read addr 0x6 (misaligned) -> no mem_en; cpu_ack=1 and err=1 at t+2; cpu_rdata=0.
5. Debug write addr 0x400 with AW=10 -> err=1 with dbg_ack at t+2; no memory change.
6. reset driven low during XFER beat 2 of a write of 0xAABBCCDD to 0x0 -> all outputs 0 immediately; mem[0]=0xAA and mem[1]=0xBB written, mem[2..3] unchanged; after release, busy=0 and the next request is served normally.
